// File: rtl/adc_multi_capture.sv
// AD7606-family parallel-mode capture: timed conversions, N-channel frame reads into an FWFT FIFO,
// output as a channel-tagged valid/ready sample stream with overflow/overrun/timeout reporting.
module adc_multi_capture #(
  parameter int NUM_CH     = 8,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int RST_CYC    = 8,
  parameter int CONV_CYC   = 4,
  parameter int RD_LO_CYC  = 3,
  parameter int RD_HI_CYC  = 2,
  parameter int BUSY_TO    = 1024
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [23:0]       sample_period,
  input  logic [4:0]        ch_count,
  output logic              adc_reset,
  output logic              adc_convst,
  input  logic              adc_busy,
  output logic              adc_cs_n,
  output logic              adc_rd_n,
  input  logic [DATA_W-1:0] adc_data,
  output logic [DATA_W-1:0] m_data,
  output logic [3:0]        m_ch,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              overflow,
  output logic              overrun,
  output logic              timeout_err,
  input  logic              err_clr,
  output logic [15:0]       frame_cnt
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int RD_CYC = RD_LO_CYC + RD_HI_CYC;
  localparam int CNT_W  = $clog2(RST_CYC + CONV_CYC + BUSY_TO + RD_CYC + 1);
  localparam int EW     = DATA_W + 5;

  typedef enum logic [2:0] {
    S_RST_ADC = 3'd0,
    S_IDLE    = 3'd1,
    S_CONV    = 3'd2,
    S_WAIT_HI = 3'd3,
    S_WAIT_LO = 3'd4,
    S_READ    = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       word_q, word_d;
  logic [4:0]       n_q, n_d;
  logic [23:0]      tmr_q;
  logic [23:0]      period_eff;
  logic [4:0]       n_eff;
  logic             tick;
  logic             space_ok;
  logic             word_last;
  logic             push, pop;
  logic             set_ovf, set_to, set_ovr, frame_done;
  logic [AW:0]      wptr_q, rptr_q, fifo_cnt;
  logic [EW-1:0]    mem [FIFO_DEPTH];
  logic [EW-1:0]    rd_word;

  // Sample timer: a period of 0 behaves as 1; disabling parks the count at 0.
  assign period_eff = (sample_period == 24'd0) ? 24'd1 : sample_period;
  assign tick       = enable && (tmr_q >= period_eff - 24'd1);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)               tmr_q <= '0;
    else if (!enable || tick) tmr_q <= '0;
    else                      tmr_q <= tmr_q + 24'd1;
  end

  always_comb begin
    n_eff = ch_count;
    if (ch_count == 5'd0 || ch_count > 5'(NUM_CH)) n_eff = 5'(NUM_CH);
  end

  // Whole-frame space check: once a frame starts, every one of its pushes is guaranteed room.
  assign space_ok  = (int'(fifo_cnt) + int'(n_eff)) <= FIFO_DEPTH;
  assign word_last = ({1'b0, word_q} == (n_q - 5'd1));

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST_ADC;
      cnt_q   <= '0;
      word_q  <= '0;
      n_q     <= 5'(NUM_CH);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      n_q     <= n_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    n_d        = n_q;
    set_ovf    = 1'b0;
    set_to     = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_RST_ADC: begin
        if (cnt_q == CNT_W'(RST_CYC - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      S_IDLE: begin
        cnt_d = '0;
        if (tick) begin
          if (space_ok) begin
            state_d = S_CONV;
            n_d     = n_eff;
          end else set_ovf = 1'b1;
        end
      end
      S_CONV: begin
        if (cnt_q == CNT_W'(CONV_CYC - 1)) begin
          state_d = S_WAIT_HI;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      S_WAIT_HI: begin
        if (adc_busy) begin
          state_d = S_WAIT_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(BUSY_TO - 1)) begin
          state_d = S_IDLE;
          set_to  = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
      S_WAIT_LO: begin
        if (!adc_busy) begin
          state_d = S_READ;
          cnt_d   = '0;
          word_d  = '0;
        end else if (cnt_q == CNT_W'(BUSY_TO - 1)) begin
          state_d = S_IDLE;
          set_to  = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
      S_READ: begin
        if (cnt_q == CNT_W'(RD_CYC - 1)) begin
          cnt_d = '0;
          if (word_last) begin
            state_d    = S_IDLE;
            frame_done = 1'b1;
          end else word_d = word_q + 4'd1;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = S_RST_ADC;
    endcase
  end

  assign adc_reset  = (state_q == S_RST_ADC);
  assign adc_convst = (state_q != S_CONV);
  assign adc_cs_n   = (state_q != S_READ);
  assign adc_rd_n   = !((state_q == S_READ) && (cnt_q < CNT_W'(RD_LO_CYC)));

  // Data is captured on the final low cycle of each rd_n strobe.
  assign push    = (state_q == S_READ) && (cnt_q == CNT_W'(RD_LO_CYC - 1));
  assign set_ovr = tick && (state_q != S_IDLE);

  // Stream: a sample transfers on every cycle where m_valid && m_ready; m_valid never
  // drops without a transfer, and m_data/m_ch/m_last hold while m_valid && !m_ready.
  assign fifo_cnt = wptr_q - rptr_q;
  assign m_valid  = (fifo_cnt != '0);
  assign pop      = m_valid && m_ready;
  assign rd_word  = mem[rptr_q[AW-1:0]];
  assign m_data   = rd_word[EW-1:5];
  assign m_ch     = rd_word[4:1];
  assign m_last   = rd_word[0];

  always_ff @(posedge sys_clk) begin
    if (push) mem[wptr_q[AW-1:0]] <= {adc_data, word_q, word_last};
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      overflow    <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (set_ovf)      overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (set_ovr)      overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;
      if (set_to)       timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_adc_multi_capture.sv
// Bench for adc_multi_capture: ADC pin model, scoreboard of expected tagged words, directed
// scenarios with randomized data, channel counts, periods and consumer backpressure.
module tb_adc_multi_capture;

  localparam int NUM_CH     = 8;
  localparam int DATA_W     = 16;
  localparam int FIFO_DEPTH = 64;

  logic              sys_clk;
  logic              rst_n;
  logic              enable;
  logic [23:0]       sample_period;
  logic [4:0]        ch_count;
  logic              adc_reset, adc_convst, adc_busy, adc_cs_n, adc_rd_n;
  logic [DATA_W-1:0] adc_data;
  logic [DATA_W-1:0] m_data;
  logic [3:0]        m_ch;
  logic              m_last, m_valid, m_ready;
  logic              overflow, overrun, timeout_err, err_clr;
  logic [15:0]       frame_cnt;

  adc_multi_capture dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .enable(enable), .sample_period(sample_period),
    .ch_count(ch_count), .adc_reset(adc_reset), .adc_convst(adc_convst), .adc_busy(adc_busy),
    .adc_cs_n(adc_cs_n), .adc_rd_n(adc_rd_n), .adc_data(adc_data), .m_data(m_data),
    .m_ch(m_ch), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .overflow(overflow), .overrun(overrun), .timeout_err(timeout_err), .err_clr(err_clr),
    .frame_cnt(frame_cnt)
  );

  int n_checks = 0;
  int n_errs   = 0;
  logic [DATA_W+4:0] exp_q[$];
  int unsigned cyc = 0;
  int unsigned conv_times[$];
  int conv_total = 0;
  int exp_frames = 0;
  int popped     = 0;
  int rd_idx     = 0;
  int cur_n      = NUM_CH;
  logic [DATA_W-1:0] cur_base = '0;
  int busy_mode = 1;
  int busy_len  = 300;
  int base_mode = 0;
  int rdy_mode  = 1;

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int eff_n(input int c);
    return (c == 0 || c > NUM_CH) ? NUM_CH : c;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic pulse_err_clr();
    @(negedge sys_clk);
    err_clr = 1'b1;
    @(negedge sys_clk);
    err_clr = 1'b0;
  endtask

  // ADC pin model: busy 2 cycles after convst falls; a new word per rd_n falling edge.
  initial begin
    logic pc, pcs, prd;
    int dly, bl;
    pc = 1'b1; pcs = 1'b1; prd = 1'b1; dly = 0; bl = 0;
    adc_busy = 1'b0;
    adc_data = '0;
    forever begin
      @(negedge sys_clk);
      if (!rst_n) begin
        adc_busy = 1'b0; dly = 0; bl = 0; pc = 1'b1; pcs = 1'b1; prd = 1'b1;
        continue;
      end
      if (dly > 0) begin
        dly--;
        if (dly == 0) begin adc_busy = 1'b1; bl = busy_len; end
      end else if (bl > 0) begin
        bl--;
        if (bl == 0) adc_busy = 1'b0;
      end
      if (pc && !adc_convst) begin
        conv_times.push_back(cyc);
        conv_total++;
        cur_n    = eff_n(int'(ch_count));
        cur_base = (base_mode != 0) ? DATA_W'($urandom & 32'hFFF0) : 16'h1000;
        if (busy_mode != 0) begin dly = 2; exp_frames++; end
      end
      if (pcs && !adc_cs_n) rd_idx = 0;
      if (prd && !adc_rd_n && !adc_cs_n) begin
        adc_data = DATA_W'(int'(cur_base) + rd_idx);
        exp_q.push_back({adc_data, 4'(rd_idx), (rd_idx == cur_n - 1)});
        rd_idx++;
      end
      if (!pcs && adc_cs_n) chk("rd_pulses", rd_idx, cur_n);
      pc = adc_convst; pcs = adc_cs_n; prd = adc_rd_n;
    end
  end

  // consumer ready driver, changes away from the sampling edge
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge sys_clk);
      #1;
      m_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    end
  end

  // scoreboard
  always @(negedge sys_clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) chk("unexpected_word", {m_data, m_ch, m_last}, 32'hDEAD);
      else chk("word", {m_data, m_ch, m_last}, exp_q.pop_front());
      popped++;
    end
  end

  initial begin
    #1_000_000;
    n_errs++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  task automatic check_intervals(input string tag, input int unsigned modulo, input bool_exact);
    for (int i = 1; i < conv_times.size(); i++) begin
      if (bool_exact != 0) chk(tag, conv_times[i] - conv_times[i-1], modulo);
      else chk(tag, (conv_times[i] - conv_times[i-1]) % modulo, 0);
    end
  endtask

  initial begin
    int c0, p0, b;
    rst_n = 1'b0; enable = 1'b0; sample_period = 24'd1000; ch_count = 5'd8; err_clr = 1'b0;
    wait_cycles(3);
    #1;
    chk("rst_adc_reset", adc_reset, 1); chk("rst_convst", adc_convst, 1);
    chk("rst_cs_n", adc_cs_n, 1);       chk("rst_rd_n", adc_rd_n, 1);
    chk("rst_m_valid", m_valid, 0);     chk("rst_flags", {overflow, overrun, timeout_err}, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    wait_cycles(12);

    // basic 8-channel frames at a 1000-cycle period
    conv_times.delete();
    enable = 1'b1;
    wait_cycles(3500);
    enable = 1'b0;
    wait_cycles(400);
    chk("t1_conv_count", conv_times.size(), 3);
    check_intervals("t1_conv_period", 1000, 1);
    chk("t1_frame_cnt", frame_cnt, exp_frames);
    chk("t1_drained", exp_q.size(), 0);

    // short frames, default count, then randomized counts/periods/backpressure
    ch_count = 5'd3; enable = 1'b1; wait_cycles(2500); enable = 1'b0; wait_cycles(400);
    ch_count = 5'd0; enable = 1'b1; wait_cycles(1500); enable = 1'b0; wait_cycles(400);
    base_mode = 1; rdy_mode = 2;
    for (int k = 0; k < 4; k++) begin
      ch_count = 5'($urandom_range(0, 20));
      sample_period = 24'($urandom_range(400, 700));
      enable = 1'b1;
      wait_cycles(2 * int'(sample_period) + 200);
      enable = 1'b0;
      wait_cycles(600);
    end
    chk("t2_frame_cnt", frame_cnt, exp_frames);
    chk("t2_no_errs", {overflow, overrun, timeout_err}, 0);
    chk("t2_drained", exp_q.size(), 0);

    // backpressure: eight frames fill the FIFO, the ninth tick is dropped
    rdy_mode = 0; ch_count = 5'd8; sample_period = 24'd1000;
    wait_cycles(5);
    c0 = conv_total;
    enable = 1'b1; wait_cycles(9500); enable = 1'b0; wait_cycles(400);
    chk("t3_overflow", overflow, 1);
    chk("t3_conv_count", conv_total - c0, 8);
    chk("t3_stored", exp_q.size(), FIFO_DEPTH);
    chk("t3_valid_held", m_valid, 1);
    p0 = popped;
    rdy_mode = 1;
    wait_cycles(100);
    chk("t3_drain_count", popped - p0, FIFO_DEPTH);
    chk("t3_empty", m_valid, 0);
    chk("t3_frame_cnt", frame_cnt, exp_frames);
    pulse_err_clr();
    chk("t3_ovf_clr", overflow, 0);

    // busy never asserted: timeout, then normal conversion on the next tick
    busy_mode = 0; sample_period = 24'd2000;
    c0 = conv_total;
    enable = 1'b1;
    b = 0;
    while (conv_total == c0 && b < 2100) begin @(negedge sys_clk); b++; end
    chk("t4_conv_seen", conv_total - c0, 1);
    b = 0;
    while (adc_convst == 1'b0 && b < 20) begin @(negedge sys_clk); b++; end
    wait_cycles(1000);
    chk("t4_to_early", timeout_err, 0);
    wait_cycles(30);
    chk("t4_to_set", timeout_err, 1);
    chk("t4_no_write", m_valid, 0);
    chk("t4_frame_cnt", frame_cnt, exp_frames);
    busy_mode = 1;
    wait_cycles(1400);
    enable = 1'b0;
    wait_cycles(400);
    chk("t4_conv_count", conv_total - c0, 2);
    chk("t4_recover_cnt", frame_cnt, exp_frames);
    chk("t4_to_sticky", timeout_err, 1);
    pulse_err_clr();
    chk("t4_to_clr", timeout_err, 0);

    // period shorter than a frame: overrun, starts stay on the tick grid
    busy_len = $urandom_range(20, 80); rdy_mode = 2; sample_period = 24'd50; ch_count = 5'd8;
    conv_times.delete();
    enable = 1'b1; wait_cycles(2000); enable = 1'b0; wait_cycles(800);
    chk("t5_overrun", overrun, 1);
    check_intervals("t5_conv_grid", 50, 0);
    chk("t5_frame_cnt", frame_cnt, exp_frames);
    chk("t5_drained", exp_q.size(), 0);
    pulse_err_clr();
    chk("t5_clr", {overflow, overrun, timeout_err}, 0);

    // reset while reading word 4
    busy_len = 300; rdy_mode = 1; sample_period = 24'd1000;
    c0 = conv_total;
    enable = 1'b1;
    b = 0;
    while (conv_total == c0 && b < 1200) begin @(negedge sys_clk); b++; end
    b = 0;
    while (!(adc_cs_n == 1'b0 && rd_idx == 5) && b < 1000) begin @(negedge sys_clk); b++; end
    chk("t6_reached_word4", rd_idx, 5);
    @(negedge sys_clk);
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    chk("t6_adc_reset", adc_reset, 1); chk("t6_convst", adc_convst, 1);
    chk("t6_cs_n", adc_cs_n, 1);       chk("t6_rd_n", adc_rd_n, 1);
    chk("t6_m_valid", m_valid, 0);     chk("t6_frame_cnt", frame_cnt, 0);
    exp_q.delete();
    exp_frames = 0;
    wait_cycles(3);
    @(negedge sys_clk);
    rst_n = 1'b1;
    b = 0;
    while (adc_reset == 1'b1 && b < 50) begin b++; @(negedge sys_clk); end
    chk("t6_adc_reset_len", b, 8);
    wait_cycles(5);
    sample_period = 24'd500;
    enable = 1'b1; wait_cycles(900); enable = 1'b0; wait_cycles(500);
    chk("t6_post_frame_cnt", frame_cnt, 1);
    chk("t6_post_model_cnt", frame_cnt, exp_frames);

    chk("leftover", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
